nibble_serial_add_ctrl: RTL

- Sequencer that computes a WIDTH-bit add or subtract using one external combinational 4-bit full-adder slice. It feeds the slice one nibble per cycle, LSB nibble first, and chains the carry through a register.
- Sits between the ALU issue logic and the shared 4-bit adder slice. This is the area-minimal ALU option: latency traded for one slice.
- Operand and result transfers use valid/ready handshakes.

---
 rtl/nibble_serial_add_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Computes a WIDTH-bit add/subtract one nibble per cycle through an external
// combinational 4-bit adder slice, with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_busy,
    output logic [3:0]       o_slice_a,
    output logic [3:0]       o_slice_b,
    output logic             o_slice_cin,
    input  logic [3:0]       i_slice_sum,
    input  logic             i_slice_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, result_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             accept;
    logic             in_run, in_done;
    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b1;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                // Handshake returns to IDLE; a new request waits for the next cycle.
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // B is stored pre-inverted for subtract so the slice always adds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            a_reg     <= i_a;
            b_reg     <= i_sub ? ~i_b : i_b;
            carry_reg <= i_sub;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            result_reg[4*cnt_reg +: 4] <= i_slice_sum;
            carry_reg                  <= i_slice_cout;
            cnt_reg                    <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign in_run  = (state_reg == RUN);
    assign in_done = (state_reg == DONE);

    assign o_slice_a   = in_run ? a_nib[cnt_reg] : 4'h0;
    assign o_slice_b   = in_run ? b_nib[cnt_reg] : 4'h0;
    assign o_slice_cin = in_run & carry_reg;

    // Result flags are only presented while the result is valid.
    assign o_sum      = in_done ? result_reg : '0;
    assign o_carry    = in_done & carry_reg;
    assign o_overflow = in_done & (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                & (result_reg[WIDTH-1] != a_reg[WIDTH-1]);
    assign o_zero     = in_done & (result_reg == '0);

endmodule
